div_seq_responder: RTL and testbench

//   Multicycle restoring divider serving as the responder side of the CPU's
//   DIV start/done handshake. The control FSM pulses start with A/B register

---
 rtl/div_seq_responder.sv | 157 +++++++++++++++
 tb/tb_div_seq_responder.sv | 139 +++++++++++++
 2 files changed

// File: rtl/div_seq_responder.sv
// -----------------------------------------------------------------------------
// div_seq_responder
//   Multicycle restoring divider on the responder side of the CPU's DIV
//   start/done handshake. An accepted start captures operand magnitudes and
//   signs. The block then produces one quotient bit per clock for WIDTH
//   clocks. One more clock applies the signs. The quotient is returned on lo
//   and the remainder on hi. A zero divisor skips the computation: it
//   completes one state later with div_zero set, and hi/lo keep their values.
//
//   Optional feature macro: DIV_SEQ_UNSIGNED_EN
//     Defined   -> adds input is_unsigned, sampled with start (1 = DIVU).
//     Undefined -> no is_unsigned port; every operation is signed.
//   Timing is identical in both builds.
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   start        request, sampled only in IDLE
//   is_unsigned  (DIV_SEQ_UNSIGNED_EN only) unsigned divide when high
//   dividend     numerator, captured on an accepted start
//   divisor      denominator, captured on an accepted start
//   busy         high while computing (CALC, FIX)
//   done         one-cycle completion pulse; hi/lo/div_zero valid
//   hi           remainder, held until the next successful completion
//   lo           quotient, held until the next successful completion
//   div_zero     high together with done when the divisor was zero
// -----------------------------------------------------------------------------
module div_seq_responder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef DIV_SEQ_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dsr;
  logic             sign_dividend;
  logic             sign_divisor;

  // Sign handling is suppressed entirely for unsigned requests.
  logic signed_op;
`ifdef DIV_SEQ_UNSIGNED_EN
  assign signed_op = ~is_unsigned;
`else
  assign signed_op = 1'b1;
`endif

  logic neg_a, neg_b;
  assign neg_a = signed_op & dividend[WIDTH-1];
  assign neg_b = signed_op & divisor[WIDTH-1];

  // One restoring step. The trial remainder is kept WIDTH+1 bits wide so an
  // unsigned divisor with its top bit set still compares correctly. The
  // result always fits back into WIDTH bits because rem < dsr.
  logic [WIDTH:0]   rem_trial;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] q_step;

  assign rem_trial = {rem, q[WIDTH-1]};
  assign rem_diff  = rem_trial - {1'b0, dsr};
  assign rem_ge    = ~rem_diff[WIDTH];
  assign rem_step  = rem_ge ? rem_diff[WIDTH-1:0] : rem_trial[WIDTH-1:0];
  assign q_step    = {q[WIDTH-2:0], rem_ge};

  assign busy = (state == S_CALC) || (state == S_FIX);
  assign done = (state == S_DONE);

  // Next-state logic.
  // NOTE: state_next gets a default before the case so that no path leaves
  // it unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (start) state_next = (divisor == '0) ? S_DONE : S_CALC;
      S_CALC: if (counter == LAST_ITER) state_next = S_FIX;
      S_FIX:  state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: all registers use non-blocking assignments. Every flop then samples
  // pre-edge values, whatever the statement order inside the block.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter       <= '0;
      rem           <= '0;
      q             <= '0;
      dsr           <= '0;
      sign_dividend <= 1'b0;
      sign_divisor  <= 1'b0;
      hi            <= '0;
      lo            <= '0;
      div_zero      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              div_zero <= 1'b1;
            end else begin
              // Magnitudes use WIDTH-bit unsigned math, so |MIN_INT| is exact.
              q             <= neg_a ? -dividend : dividend;
              dsr           <= neg_b ? -divisor  : divisor;
              sign_dividend <= neg_a;
              sign_divisor  <= neg_b;
              rem           <= '0;
              counter       <= '0;
            end
          end
        end
        S_CALC: begin
          rem     <= rem_step;
          q       <= q_step;
          counter <= counter + 1'b1;
        end
        S_FIX: begin
          // Quotient truncates toward zero. The remainder follows the
          // dividend's sign. MIN_INT / -1 wraps back to MIN_INT.
          lo <= (sign_dividend ^ sign_divisor) ? -q : q;
          hi <= sign_dividend ? -rem : rem;
        end
        S_DONE: begin
          div_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_responder.sv
// -----------------------------------------------------------------------------
// tb_div_seq_responder
//   Directed-vector bench for div_seq_responder (WIDTH=32). Inputs change on
//   the falling edge. Outputs are sampled 1 ns after the rising edge.
//   Latency is counted in rising edges after the edge that accepted start.
//   A normal divide therefore completes at 33. A zero divisor moves straight
//   to DONE on the accepting edge, so its count is 0.
// -----------------------------------------------------------------------------
module tb_div_seq_responder;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         is_unsigned;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_zero;

  int checks = 0;
  int errors = 0;

  div_seq_responder #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
`ifdef DIV_SEQ_UNSIGNED_EN
    .is_unsigned (is_unsigned),
`endif
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_zero    (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request and check the result, the latency and the follow-up
  // cycle. After acceptance the operands are scrambled to confirm they are
  // not re-sampled.
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic uns, input logic [W-1:0] exp_lo,
                         input logic [W-1:0] exp_hi, input logic exp_dz,
                         input int exp_lat);
    int n;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b; is_unsigned = uns;
    @(posedge clk); #1;
    start = 1'b0; dividend = 32'hDEAD_BEEF; divisor = 32'h0000_0003; is_unsigned = 1'b0;
    check({tag, ".busy"}, 64'(busy), 64'(!exp_dz));
    n = 0;
    while (!done && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".latency"}, 64'(n), 64'(exp_lat));
    check({tag, ".lo"}, 64'(lo), 64'(exp_lo));
    check({tag, ".hi"}, 64'(hi), 64'(exp_hi));
    check({tag, ".div_zero"}, 64'(div_zero), 64'(exp_dz));
    @(posedge clk); #1;
    check({tag, ".done_drop"}, 64'(done), 64'(0));
    check({tag, ".dz_drop"}, 64'(div_zero), 64'(0));
  endtask

  initial begin
    int done_cnt;
    reset = 1'b1; start = 1'b0; is_unsigned = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", 64'(busy), 64'(0));
    check("reset.done", 64'(done), 64'(0));
    check("reset.hi", 64'(hi), 64'(0));
    check("reset.lo", 64'(lo), 64'(0));
    check("reset.div_zero", 64'(div_zero), 64'(0));
    @(negedge clk); reset = 1'b0;

    // Basic positive divide, then divide-by-zero keeps the previous result.
    run_div("pos", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33);
    run_div("dz", 32'd5, 32'd0, 1'b0, 32'd14, 32'd2, 1'b1, 0);

    // Sign combinations.
    run_div("neg_pos", 32'hFFFF_FF9C, 32'd7, 1'b0, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33);
    run_div("pos_neg", 32'd100, 32'hFFFF_FFF9, 1'b0, 32'hFFFF_FFF2, 32'd2, 1'b0, 33);
    run_div("neg_neg", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0, 32'd14, 32'hFFFF_FFFE, 1'b0, 33);

    // Boundary cases.
    run_div("minint_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 32'd0, 1'b0, 33);
    run_div("small_big", 32'd7, 32'd100, 1'b0, 32'd0, 32'd7, 1'b0, 33);
    run_div("minint_2", 32'h8000_0000, 32'd2, 1'b0, 32'hC000_0000, 32'd0, 1'b0, 33);
    run_div("minint_minint", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'd1, 32'd0, 1'b0, 33);

    // Mid-operation reset: ignored second start, then abort with no done.
    done_cnt = 0;
    @(negedge clk); start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1; start = 1'b0;                          // edge 0
    for (int i = 1; i <= 4; i++) begin @(posedge clk); #1; done_cnt += int'(done); end
    @(negedge clk); start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk); #1; start = 1'b0; done_cnt += int'(done);  // edge 5
    check("abort.busy_mid", 64'(busy), 64'(1));
    for (int i = 6; i <= 9; i++) begin @(posedge clk); #1; done_cnt += int'(done); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; done_cnt += int'(done);                 // edge 10
    check("abort.busy", 64'(busy), 64'(0));
    check("abort.hi", 64'(hi), 64'(0));
    check("abort.lo", 64'(lo), 64'(0));
    check("abort.div_zero", 64'(div_zero), 64'(0));
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; done_cnt += int'(done); end
    check("abort.no_done", 64'(done_cnt), 64'(0));
    run_div("after_abort", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 33);

`ifdef DIV_SEQ_UNSIGNED_EN
    run_div("divu", 32'hFFFF_FFFF, 32'd2, 1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0, 33);
    run_div("div_s", 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
    run_div("divu_big", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'd1, 1'b0, 33);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
